// File: rtl/bnn_pkg.sv
// Shared definitions for the binary neural network stages.
// Holds the default geometry of the dense/argmax classifier and the
// controller state type.
package bnn_pkg;

   localparam int unsigned BNN_IN_BITS     = 196;  // 14x14 pooled map
   localparam int unsigned BNN_NUM_CLASSES = 10;
   localparam int unsigned BNN_CNT_W       = $clog2(BNN_IN_BITS + 1);
   localparam int unsigned BNN_CLS_W       = $clog2(BNN_NUM_CLASSES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RUN,
      S_DONE
   } state_e;

endpackage

// File: rtl/bnn_popcount.sv
// XNOR + popcount of a binary feature vector against a binary weight row.
// Purely combinational, reusable by convolution stages.
// Ports:
//   vec_i   : binary feature vector
//   wgt_i   : binary weight row
//   score_o : number of agreeing bit positions (0..IN_BITS)
module bnn_popcount
   import bnn_pkg::*;
#(
   parameter int unsigned IN_BITS = BNN_IN_BITS,
   parameter int unsigned CNT_W   = $clog2(IN_BITS + 1)
) (
   input  logic [IN_BITS-1:0] vec_i,
   input  logic [IN_BITS-1:0] wgt_i,
   output logic [CNT_W-1:0]   score_o
);

   logic [IN_BITS-1:0] match;

   assign match = ~(vec_i ^ wgt_i);

   always_comb begin
      score_o = '0;
      for (int unsigned i = 0; i < IN_BITS; i++) begin
         score_o = score_o + CNT_W'(match[i]);
      end
   end

endmodule

// File: rtl/bnn_dense_argmax.sv
// Binary dense layer with argmax: scores one class per cycle by fetching
// its weight row from external memory and keeps the best (lowest index
// wins ties).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready/in_vec : feature vector input handshake
//   w_en/w_addr/w_data    : weight row read (data one cycle after w_en)
//   out_valid/out_ready   : result handshake
//   out_class/out_score   : winning class and its XNOR-popcount score
module bnn_dense_argmax
   import bnn_pkg::*;
#(
   parameter int unsigned IN_BITS     = BNN_IN_BITS,
   parameter int unsigned NUM_CLASSES = BNN_NUM_CLASSES,
   parameter int unsigned CNT_W       = $clog2(IN_BITS + 1),
   parameter int unsigned CLS_W       = $clog2(NUM_CLASSES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_BITS-1:0] in_vec,
   output logic               w_en,
   output logic [CLS_W-1:0]   w_addr,
   input  logic [IN_BITS-1:0] w_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CLS_W-1:0]   out_class,
   output logic [CNT_W-1:0]   out_score
);

   localparam logic [CLS_W-1:0] LAST = CLS_W'(NUM_CLASSES - 1);

   state_e             state_q, state_d;
   logic [CLS_W-1:0]   k_q, k_d;
   logic [IN_BITS-1:0] vec_q, vec_d;
   logic [CLS_W-1:0]   best_cls_q, best_cls_d;
   logic [CNT_W-1:0]   best_sc_q, best_sc_d;
   logic               w_en_q, w_en_d;
   logic [CLS_W-1:0]   w_addr_q, w_addr_d;
   logic [CNT_W-1:0]   score;

   bnn_popcount #(
      .IN_BITS (IN_BITS),
      .CNT_W   (CNT_W)
   ) u_popcount (
      .vec_i   (vec_q),
      .wgt_i   (w_data),
      .score_o (score)
   );

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      vec_d      = vec_q;
      best_cls_d = best_cls_q;
      best_sc_d  = best_sc_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               vec_d   = in_vec;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            k_d     = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            // Class 0 always seeds the best; strict > keeps lower index on ties.
            if ((k_q == '0) || (score > best_sc_q)) begin
               best_cls_d = k_q;
               best_sc_d  = score;
            end
            if (k_q == LAST) begin
               state_d = S_DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Read strobe is registered, so it is derived from the next state:
      // ISSUE fetches row 0, RUN on row k pre-fetches row k+1.
      w_en_d   = (state_d == S_ISSUE) || ((state_d == S_RUN) && (k_d != LAST));
      w_addr_d = '0;
      if ((state_d == S_RUN) && w_en_d) begin
         w_addr_d = k_d + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         vec_q      <= '0;
         best_cls_q <= '0;
         best_sc_q  <= '0;
         w_en_q     <= 1'b0;
         w_addr_q   <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         vec_q      <= vec_d;
         best_cls_q <= best_cls_d;
         best_sc_q  <= best_sc_d;
         w_en_q     <= w_en_d;
         w_addr_q   <= w_addr_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_class = out_valid ? best_cls_q : '0;
   assign out_score = out_valid ? best_sc_q : '0;
   assign w_en      = w_en_q;
   assign w_addr    = w_addr_q;

endmodule

// File: tb/tb_bnn_dense_argmax.sv
// Self-checking bench for bnn_dense_argmax: directed scenarios plus random
// images compared against a behavioural argmax-of-popcount model.
module tb_bnn_dense_argmax;

   localparam int IN = 196;
   localparam int NC = 10;
   localparam int CW = 8;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [IN-1:0] in_vec;
   logic          w_en;
   logic [LW-1:0] w_addr;
   logic [IN-1:0] w_data;
   logic          out_valid;
   logic          out_ready;
   logic [LW-1:0] out_class;
   logic [CW-1:0] out_score;

   logic [IN-1:0] wmem [NC];
   int tests = 0;
   int fails = 0;
   int last_cls, last_sc;

   always #5 clk = ~clk;

   bnn_dense_argmax #(
      .IN_BITS     (IN),
      .NUM_CLASSES (NC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .w_en      (w_en),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_score (out_score)
   );

   function automatic logic [IN-1:0] rand_vec();
      logic [IN-1:0] v;
      for (int i = 0; i < IN; i++) v[i] = 1'($urandom_range(1, 0));
      return v;
   endfunction

   function automatic logic [IN-1:0] rand_mask(input int n);
      logic [IN-1:0] m = '0;
      while ($countones(m) < n) m[$urandom_range(IN - 1, 0)] = 1'b1;
      return m;
   endfunction

   // Weight memory: row returned one cycle after the strobe, noise otherwise.
   always @(posedge clk) begin
      if (w_en && (int'(w_addr) < NC)) w_data <= wmem[w_addr];
      else                             w_data <= rand_vec();
   end

   // Reference: score = number of agreeing bits; first maximum wins.
   task automatic model(input logic [IN-1:0] v, output int cls, output int sc);
      cls = 0;
      sc  = -1;
      for (int k = 0; k < NC; k++) begin
         int s = $countones(~(v ^ wmem[k]));
         if (s > sc) begin
            sc  = s;
            cls = k;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_image(input logic [IN-1:0] v, input int hold, input string tag);
      int ecls, esc, n, hcls, hsc;
      int addrs[$];
      model(v, ecls, esc);
      @(negedge clk);
      chk({tag, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      in_vec   = v;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         if (w_en) begin
            addrs.push_back(int'(w_addr));
            chk({tag, "_w_addr_range"}, int'(w_addr) < NC, 1);
         end else begin
            chk({tag, "_w_addr_idle"}, w_addr, 0);
         end
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n + 1, NC + 2);
      chk({tag, "_n_reads"}, addrs.size(), NC);
      for (int i = 0; i < addrs.size(); i++) chk({tag, "_w_addr_seq"}, addrs[i], i);
      chk({tag, "_class"}, out_class, ecls);
      chk({tag, "_score"}, out_score, esc);
      last_cls = int'(out_class);
      last_sc  = int'(out_score);
      hcls = int'(out_class);
      hsc  = int'(out_score);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, out_valid, 1);
         chk({tag, "_hold_class"}, out_class, hcls);
         chk({tag, "_hold_score"}, out_score, hsc);
         chk({tag, "_hold_in_ready"}, in_ready, 0);
         chk({tag, "_hold_w_en"}, w_en, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_release_valid"}, out_valid, 0);
      chk({tag, "_release_in_ready"}, in_ready, 1);
   endtask

   initial begin
      int n, got, ecls, esc, seen, pend;
      int hs[$];
      int addrs[$];
      int expq[$];
      logic [IN-1:0] v;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
      for (int k = 0; k < NC; k++) wmem[k] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_class", out_class, 0);
      chk("rst_out_score", out_score, 0);
      chk("rst_w_en", w_en, 0);
      chk("rst_w_addr", w_addr, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);

      // Zero input, row 3 zero, others ones: perfect match on class 3
      for (int k = 0; k < NC; k++) wmem[k] = '1;
      wmem[3] = '0;
      run_image('0, 0, "row3");
      chk("row3_const_class", last_cls, 3);
      chk("row3_const_score", last_sc, IN);

      // All rows identical: tie resolves to class 0
      v = rand_vec();
      for (int k = 0; k < NC; k++) wmem[k] = v;
      run_image(rand_vec(), 0, "ties");
      chk("ties_const_class", last_cls, 0);

      // Row 7 differs in 5 bits, others in 100 bits
      v = rand_vec();
      for (int k = 0; k < NC; k++) wmem[k] = v ^ rand_mask(100);
      wmem[7] = v ^ rand_mask(5);
      run_image(v, 0, "row7");
      chk("row7_const_class", last_cls, 7);
      chk("row7_const_score", last_sc, IN - 5);

      // Back-pressure: consumer holds off 20 cycles
      for (int k = 0; k < NC; k++) wmem[k] = rand_vec();
      run_image(rand_vec(), 20, "hold");

      // Random images, fully random and near-tie weight sets
      for (int t = 0; t < 6; t++) begin
         v = rand_vec();
         for (int k = 0; k < NC; k++)
            wmem[k] = (t % 2 == 0) ? rand_vec() : (v ^ rand_mask($urandom_range(3, 0)));
         run_image(v, $urandom_range(3, 0), "rand");
      end

      // Reset mid-run: no result, next image correct
      for (int k = 0; k < NC; k++) wmem[k] = rand_vec();
      @(negedge clk);
      in_valid = 1'b1;
      in_vec   = rand_vec();
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      chk("midrst_no_out_valid", seen, 0);
      chk("midrst_in_ready", in_ready, 1);
      run_image(rand_vec(), 0, "after_rst");

      // in_valid held high: one acceptance every NC+3 cycles
      for (int k = 0; k < NC; k++) wmem[k] = rand_vec();
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_vec    = rand_vec();
      n = 0; got = 0; pend = 0;
      while (got < 3 && n < 80) begin
         if (n > 0) @(negedge clk);
         if (pend != 0) begin
            in_vec = rand_vec();
            pend   = 0;
         end
         if (w_en) addrs.push_back(int'(w_addr));
         if (out_valid) begin
            if (expq.size() >= 2) begin
               chk("stream_class", out_class, expq.pop_front());
               chk("stream_score", out_score, expq.pop_front());
            end else begin
               chk("stream_unexpected_out", 1, 0);
            end
            got++;
         end
         if (in_ready) begin
            hs.push_back(n);
            model(in_vec, ecls, esc);
            expq.push_back(ecls);
            expq.push_back(esc);
            pend = 1;
         end
         n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("stream_results", got, 3);
      chk("stream_accepts", hs.size(), 3);
      for (int i = 1; i < hs.size(); i++) chk("stream_spacing", hs[i] - hs[i-1], NC + 3);
      chk("stream_n_reads", addrs.size(), 3 * NC);
      for (int i = 0; i < addrs.size(); i++) chk("stream_w_addr_seq", addrs[i], i % NC);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bnn_dense_argmax.md
BNN_DENSE_ARGMAX -- requirements
Module: bnn_dense_argmax

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- IN_BITS, 196: pooled feature-map width, 14x14 max-pool output.
- NUM_CLASSES, 10: output neurons.
- CNT_W, $clog2(IN_BITS+1): score width.
- CLS_W, $clog2(NUM_CLASSES): class index width.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: in_vec valid.
- in_ready, out, 1: block can accept in_vec.
- in_vec, in, IN_BITS: pooled binary features, bit r*14+c.
- w_en, out, 1: weight-row read strobe.
- w_addr, out, CLS_W: weight row index.
- w_data, in, IN_BITS: weight row; valid exactly 1 cycle after w_en.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts result.
- out_class, out, CLS_W: winning class index.
- out_score, out, CNT_W: winning XNOR-popcount score.

REQ-003 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 Score(k) SHALL be popcount(~(in_vec ^ W[k])), range 0..IN_BITS, with no truncation.
REQ-005 The FSM SHALL have exactly four states:
- IDLE: in_ready=1.
- ISSUE: w_en=1, w_addr=0.
- RUN: evaluate row k; issue row k+1 when k<NUM_CLASSES-1.
- DONE: out_valid=1.
REQ-006 An input handshake (in_valid and in_ready) SHALL register in_vec and move IDLE->ISSUE; in_valid outside IDLE SHALL be ignored.
REQ-007 ISSUE->RUN SHALL be unconditional; RUN SHALL evaluate one class per cycle in order 0..NUM_CLASSES-1; RUN->DONE SHALL occur after class NUM_CLASSES-1 is evaluated.
REQ-008 The argmax update SHALL use strict greater-than; ties SHALL keep the lower index; class 0 SHALL always initialise best.
REQ-009 With handshake at cycle T, out_valid SHALL rise at T+NUM_CLASSES+2 (T+12 by default).
REQ-010 out_valid, out_class and out_score SHALL be held stable in DONE until out_ready=1; that handshake SHALL move DONE->IDLE.
REQ-011 in_ready SHALL be 1 only in IDLE; minimum spacing between accepted inputs SHALL be NUM_CLASSES+3 cycles.
REQ-012 w_en SHALL be registered; w_addr SHALL be 0 when w_en=0; no read SHALL be issued beyond NUM_CLASSES-1.

Reset
REQ-013 When rst=1, the block SHALL go to IDLE and drive out_valid=0, out_class=0, out_score=0, w_en=0, w_addr=0; in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-014 Reset during ISSUE, RUN or DONE SHALL discard the image in flight without emitting a result; a w_data return after reset SHALL be ignored.

Structure
REQ-015 The following SHALL live in shared package bnn_pkg: IN_BITS, NUM_CLASSES, CNT_W, CLS_W defaults, and the state enum type.
REQ-016 XNOR+popcount SHALL be a separate combinational sub-module bnn_popcount (IN_BITS in, CNT_W out), reusable by conv stages.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- in_vec=0; row 3 all-0, other rows all-1 -> out_class=3, out_score=196, out_valid at T+12.
- All rows identical -> out_class=0, tie kept lowest.
- Row 7 matches in_vec except 5 bits, all others differ in 100 bits -> class 7, score 191.
- out_ready low 20 cycles -> outputs stable, in_ready=0, no w_en; release -> IDLE, in_ready=1 next cycle.
- rst pulsed at T+6 -> no out_valid, next image result correct.
- in_valid held high continuously -> accepts every 13 cycles, w_addr sequence 0..9 per image.
